i2c_xfer_sequencer: RTL and testbench
=====================================

# i2c_xfer_sequencer

Hardware Wishbone master that drives the IICMB I2C controller (`iicmb_m_wb`) through complete I2C transactions without software. It accepts one transfer request (bus, slave address, direction, length) and issues the full register-level command sequence: enable, set bus, start, address, data bytes, stop. It handles `irq` waits, status checks and data streaming. It sits between a simple request/stream client and the IICMB Wishbone slave port.

## Interface

**Parameters**
- `WB_ADDR_WIDTH`, default 2: Wishbone address width.
- `WB_DATA_WIDTH`, default 8: Wishbone data width.
- `I2C_ADDR_WIDTH`, default 7: slave address width.
- `MAX_LEN`, default 32: maximum bytes per transfer. The length field is `$clog2(MAX_LEN+1)` bits wide.
- `IRQ_TIMEOUT`, default 65535: maximum number of cycles to wait for `irq_i` per command.

**Ports** (clock and reset first)
- `clk_i`, in, 1: clock. Single clock domain.
- `rst_i`, in, 1: reset. Synchronous, active-high.
- `req_valid_i`, in, 1: transfer request valid.
- `req_ready_o`, out, 1: high only in IDLE.
- `req_rw_i`, in, 1: transfer direction. 0 = write, 1 = read.
- `req_bus_i`, in, 8: IICMB bus id.
- `req_addr_i`, in, `I2C_ADDR_WIDTH`: slave address.
- `req_len_i`, in, `$clog2(MAX_LEN+1)`: byte count, 1..`MAX_LEN`.
- `wr_data_i`, in, 8: write-data stream byte.
- `wr_valid_i`, in, 1: write-data valid.
- `wr_ready_o`, out, 1: write-data ready.
- `rd_data_o`, out, 8: read byte.
- `rd_valid_o`, out, 1: one-cycle pulse per read byte.
- `done_o`, out, 1: one-cycle pulse at the end of each transfer.
- `status_o`, out, 2: transfer result. 0 = OK, 1 = NAK, 2 = arbitration lost, 3 = error/timeout. Held until the next request is accepted.
- `cyc_o`, `stb_o`, `we_o`, out, 1 each: Wishbone master control.
- `adr_o`, out, `WB_ADDR_WIDTH`: Wishbone address.
- `dat_o`, out, `WB_DATA_WIDTH`: Wishbone write data.
- `dat_i`, in, `WB_DATA_WIDTH`: Wishbone read data.
- `ack_i`, in, 1: Wishbone acknowledge.
- `irq_i`, in, 1: IICMB interrupt request.

## Operation

**IICMB register map.** CSR=0, DPR=1, CMDR=2, FSMR=3.

**Commands** (CMDR[2:0]): WRITE=001, READ_ACK=010, READ_NAK=011, START=100, STOP=101, SET_BUS=110.

**Status** (read back from CMDR): bit7 DON, bit6 NAK, bit5 AL, bit4 ERR.

**States**
- **INIT**: entered after reset. Write CSR=0xC0 (enable + interrupt enable), then go to IDLE.
- **IDLE**: `req_ready_o`=1. On `req_valid_i` & `req_ready_o`, latch all `req_*` fields and clear the byte counter.
- **SETBUS**: write DPR=bus, write CMDR=0x06, then do a CMD_WAIT.
- **START**: write CMDR=0x04, then CMD_WAIT.
- **ADDR**: write DPR={addr, rw}, write CMDR=0x01, then CMD_WAIT.
- **WDATA**: assert `wr_ready_o` until a `wr_valid_i` handshake. Then write DPR=byte, write CMDR=0x01, CMD_WAIT.
- **RDATA**: write CMDR=0x02, or 0x03 for the last byte. Then CMD_WAIT, read DPR, pulse `rd_valid_o` with `rd_data_o`=DPR value.
- **STOP**: write CMDR=0x05, then CMD_WAIT.
- **DONE**: pulse `done_o` and return to IDLE.

**CMD_WAIT.** Wait for `irq_i`=1, then read CMDR. Reading CMDR clears `irq`.
- DON: continue to the next step.
- NAK (at ADDR or WDATA): go to STOP, then `status_o`=1.
- AL (anywhere): go to DONE with `status_o`=2 and skip STOP, because the bus is already released.
- ERR, or `IRQ_TIMEOUT` cycles without `irq_i`: `status_o`=3, write CSR=0x00 then CSR=0xC0 (controller re-init), then go to DONE.

**Byte counter.** Increments after each data byte. The transfer ends when count == latched length.

**Bad length.** `req_len_i`=0 or >`MAX_LEN` is still accepted. It produces `done_o` with `status_o`=3 and no Wishbone traffic.

## Timing

**Reset values.** All outputs are 0, except that `req_ready_o` is 0 until INIT completes. The FSM goes to INIT.

**Reset mid-operation.** `cyc_o`/`stb_o` fall at the reset edge. No pulses are emitted. After release the block restarts from INIT.

**Wishbone access**
- Drive `cyc_o`=`stb_o`=1 with `adr_o`/`dat_o`/`we_o` stable until `ack_i` is sampled high.
- Read data is captured on the ack cycle.
- Deassert `cyc_o`/`stb_o` on the next cycle. Every access is followed by at least one idle cycle.

**Latencies**
- `req_ready_o` falls 1 cycle after acceptance.
- `rd_valid_o` comes 1 cycle after the DPR read ack.
- `done_o` comes 1 cycle after the final CMDR read ack (or after the DONE entry cycle when skipping).

**`irq_i` sampling.** `irq_i` is sampled only in CMD_WAIT. The timeout counter resets on every CMD_WAIT entry.

## Structure

**Package `i2c_xfer_seq_pkg`**
- Register address constants.
- Command codes.
- CMDR status bit indices.
- `status_e` enum (OK, NAK, AL, ERR).
- FSM state enum.

**Sub-module `i2c_seq_wb_access`.** A single Wishbone transaction engine:
- Inputs: start, we, adr, wdata.
- Outputs: busy, done, rdata.

The top level holds the transaction FSM, the counters and the timeout logic.

## Test plan

- **Write transfer.** Reset, then write bus=0, addr=0x22, len=4, bytes 0x00..0x03 against IICMB plus an I2C slave model.
  - Required: CSR=0xC0, then DPR=0x00, CMDR=0x06, CMDR=0x04, DPR=0x44, CMDR=0x01.
  - Then 4×(DPR=byte, CMDR=0x01), then CMDR=0x05.
  - Slave receives 00..03. `done_o`=1 with `status_o`=0.
- **Read transfer.** Read addr=0x22, len=3, slave returns 0xA5, 0x5A, 0xFF.
  - Required: DPR=0x45, then CMDR 0x02, 0x02, 0x03.
  - Three `rd_valid_o` pulses with those values, in order. `status_o`=0.
- **Address NAK.** Slave NAKs the address.
  - Required: no data commands, CMDR=0x05 is issued, `status_o`=1.
- **Write-data backpressure.** Hold `wr_valid_i` low for 50 cycles mid-transfer.
  - Required: no Wishbone traffic during the stall, `wr_ready_o` stays high, the transfer completes OK.
- **Timeout.** Hold `irq_i` at 0 with `IRQ_TIMEOUT`=100.
  - Required: after 100 cycles, CSR=0x00 then CSR=0xC0 are written, `status_o`=3, `done_o` pulses.
- **Reset mid-transfer, then bad length.** Assert `rst_i` during RDATA.
  - Required: `cyc_o` is 0 the next cycle, then the INIT sequence runs again.
  - Then issue `req_len_i`=0. Required: `done_o` with `status_o`=3 and zero Wishbone cycles.

Source files
------------

// File: rtl/i2c_xfer_seq_pkg.sv
// Shared constants and types for the IICMB transfer sequencer: register map,
// command codes, status bits and the sequencer state encodings.
package i2c_xfer_seq_pkg;

    localparam logic [1:0] REG_CSR  = 2'd0;
    localparam logic [1:0] REG_DPR  = 2'd1;
    localparam logic [1:0] REG_CMDR = 2'd2;

    localparam logic [2:0] CMD_WRITE    = 3'b001;
    localparam logic [2:0] CMD_READ_ACK = 3'b010;
    localparam logic [2:0] CMD_READ_NAK = 3'b011;
    localparam logic [2:0] CMD_START    = 3'b100;
    localparam logic [2:0] CMD_STOP     = 3'b101;
    localparam logic [2:0] CMD_SET_BUS  = 3'b110;

    localparam logic [7:0] CSR_ENABLE  = 8'hC0;
    localparam logic [7:0] CSR_DISABLE = 8'h00;

    localparam int unsigned STAT_DON = 7;
    localparam int unsigned STAT_NAK = 6;
    localparam int unsigned STAT_AL  = 5;
    localparam int unsigned STAT_ERR = 4;

    typedef enum logic [1:0] {
        ST_OK  = 2'd0,
        ST_NAK = 2'd1,
        ST_AL  = 2'd2,
        ST_ERR = 2'd3
    } status_e;

    typedef enum logic [4:0] {
        S_INIT, S_IDLE,
        S_BUS_DPR, S_BUS_CMD, S_START_CMD, S_ADDR_DPR, S_ADDR_CMD,
        S_WR_WAIT, S_WR_DPR, S_WR_CMD, S_RD_CMD, S_RD_DPR, S_STOP_CMD,
        S_WAIT_IRQ, S_WAIT_STAT, S_REINIT_OFF, S_REINIT_ON, S_DONE
    } state_e;

    // Which command the pending CMD_WAIT belongs to.
    typedef enum logic [2:0] {
        PH_BUS, PH_START, PH_ADDR, PH_WDATA, PH_RDATA, PH_STOP
    } phase_e;

endpackage

// File: rtl/i2c_seq_wb_access.sv
// Single Wishbone master transaction engine. Holds cyc/stb until ack, then
// drops them; new starts are ignored while busy, guaranteeing an idle cycle.
module i2c_seq_wb_access #(
    parameter int unsigned AW = 2,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          we,
    input  logic [AW-1:0] adr,
    input  logic [DW-1:0] wdata,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] rdata,
    output logic          wb_cyc,
    output logic          wb_stb,
    output logic          wb_we,
    output logic [AW-1:0] wb_adr,
    output logic [DW-1:0] wb_dat_w,
    input  logic [DW-1:0] wb_dat_r,
    input  logic          wb_ack
);

    logic cyc;

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc      <= 1'b0;
            wb_we    <= 1'b0;
            wb_adr   <= '0;
            wb_dat_w <= '0;
        end else if (!cyc && start) begin
            cyc      <= 1'b1;
            wb_we    <= we;
            wb_adr   <= adr;
            wb_dat_w <= wdata;
        end else if (cyc && wb_ack) begin
            cyc <= 1'b0;
        end
    end

    // done/rdata are valid in the ack cycle so the caller captures there.
    assign busy   = cyc;
    assign done   = cyc & wb_ack;
    assign rdata  = wb_dat_r;
    assign wb_cyc = cyc;
    assign wb_stb = cyc;

endmodule

// File: rtl/i2c_xfer_sequencer.sv
// Wishbone master that sequences complete I2C transfers through an IICMB
// controller: enable, set bus, start, address, data bytes, stop.
module i2c_xfer_sequencer
    import i2c_xfer_seq_pkg::*;
#(
    parameter int unsigned WB_ADDR_WIDTH  = 2,
    parameter int unsigned WB_DATA_WIDTH  = 8,
    parameter int unsigned I2C_ADDR_WIDTH = 7,
    parameter int unsigned MAX_LEN        = 32,
    parameter int unsigned IRQ_TIMEOUT    = 65535,
    localparam int unsigned LEN_W         = $clog2(MAX_LEN + 1),
    localparam int unsigned TMO_W         = $clog2(IRQ_TIMEOUT + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_rw_i,
    input  logic [7:0]                req_bus_i,
    input  logic [I2C_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [LEN_W-1:0]          req_len_i,
    input  logic [7:0]                wr_data_i,
    input  logic                      wr_valid_i,
    output logic                      wr_ready_o,
    output logic [7:0]                rd_data_o,
    output logic                      rd_valid_o,
    output logic                      done_o,
    output logic [1:0]                status_o,
    output logic                      cyc_o,
    output logic                      stb_o,
    output logic                      we_o,
    output logic [WB_ADDR_WIDTH-1:0]  adr_o,
    output logic [WB_DATA_WIDTH-1:0]  dat_o,
    input  logic [WB_DATA_WIDTH-1:0]  dat_i,
    input  logic                      ack_i,
    input  logic                      irq_i
);

    localparam int unsigned AW = WB_ADDR_WIDTH;
    localparam int unsigned DW = WB_DATA_WIDTH;

    state_e                    state, state_n;
    phase_e                    phase;
    status_e                   status, status_val;
    logic                      status_set;
    logic                      rw;
    logic [7:0]                bus;
    logic [I2C_ADDR_WIDTH-1:0] addr;
    logic [LEN_W-1:0]          len, cnt;
    logic [7:0]                wbyte;
    logic [TMO_W-1:0]          tmo;
    logic                      rd_valid;
    logic [7:0]                rd_data;
    logic                      cnt_inc;

    logic          acc_req, acc_start, acc_we, acc_busy, acc_done;
    logic [AW-1:0] acc_adr;
    logic [DW-1:0] acc_wdata, acc_rdata;

    logic accept, bad_len, last_byte;

    assign accept    = (state == S_IDLE) && req_valid_i;
    assign bad_len   = (req_len_i == '0) || (req_len_i > LEN_W'(MAX_LEN));
    assign last_byte = (cnt == len - LEN_W'(1));
    assign acc_start = acc_req && !acc_busy;

    i2c_seq_wb_access #(.AW(AW), .DW(DW)) u_acc (
        .clk      (clk_i),
        .rst      (rst_i),
        .start    (acc_start),
        .we       (acc_we),
        .adr      (acc_adr),
        .wdata    (acc_wdata),
        .busy     (acc_busy),
        .done     (acc_done),
        .rdata    (acc_rdata),
        .wb_cyc   (cyc_o),
        .wb_stb   (stb_o),
        .wb_we    (we_o),
        .wb_adr   (adr_o),
        .wb_dat_w (dat_o),
        .wb_dat_r (dat_i),
        .wb_ack   (ack_i)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_INIT;
        else       state <= state_n;
    end

    always_comb begin
        state_n    = state;
        acc_req    = 1'b0;
        acc_we     = 1'b1;
        acc_adr    = AW'(REG_CSR);
        acc_wdata  = '0;
        status_set = 1'b0;
        status_val = ST_OK;
        cnt_inc    = 1'b0;
        unique case (state)
            S_INIT: begin
                acc_req = 1'b1; acc_wdata = DW'(CSR_ENABLE);
                if (acc_done) state_n = S_IDLE;
            end
            S_IDLE:
                if (req_valid_i) state_n = bad_len ? S_DONE : S_BUS_DPR;
            S_BUS_DPR: begin
                acc_req = 1'b1; acc_adr = AW'(REG_DPR); acc_wdata = DW'(bus);
                if (acc_done) state_n = S_BUS_CMD;
            end
            S_BUS_CMD: begin
                acc_req = 1'b1; acc_adr = AW'(REG_CMDR); acc_wdata = DW'({5'b0, CMD_SET_BUS});
                if (acc_done) state_n = S_WAIT_IRQ;
            end
            S_START_CMD: begin
                acc_req = 1'b1; acc_adr = AW'(REG_CMDR); acc_wdata = DW'({5'b0, CMD_START});
                if (acc_done) state_n = S_WAIT_IRQ;
            end
            S_ADDR_DPR: begin
                acc_req = 1'b1; acc_adr = AW'(REG_DPR); acc_wdata = DW'({addr, rw});
                if (acc_done) state_n = S_ADDR_CMD;
            end
            S_ADDR_CMD, S_WR_CMD: begin
                acc_req = 1'b1; acc_adr = AW'(REG_CMDR); acc_wdata = DW'({5'b0, CMD_WRITE});
                if (acc_done) state_n = S_WAIT_IRQ;
            end
            S_WR_WAIT:
                if (wr_valid_i) state_n = S_WR_DPR;
            S_WR_DPR: begin
                acc_req = 1'b1; acc_adr = AW'(REG_DPR); acc_wdata = DW'(wbyte);
                if (acc_done) state_n = S_WR_CMD;
            end
            S_RD_CMD: begin
                acc_req = 1'b1; acc_adr = AW'(REG_CMDR);
                acc_wdata = DW'({5'b0, last_byte ? CMD_READ_NAK : CMD_READ_ACK});
                if (acc_done) state_n = S_WAIT_IRQ;
            end
            S_RD_DPR: begin
                acc_req = 1'b1; acc_we = 1'b0; acc_adr = AW'(REG_DPR);
                if (acc_done) begin
                    cnt_inc = 1'b1;
                    state_n = last_byte ? S_STOP_CMD : S_RD_CMD;
                end
            end
            S_STOP_CMD: begin
                acc_req = 1'b1; acc_adr = AW'(REG_CMDR); acc_wdata = DW'({5'b0, CMD_STOP});
                if (acc_done) state_n = S_WAIT_IRQ;
            end
            S_WAIT_IRQ:
                if (irq_i) state_n = S_WAIT_STAT;
                else if (tmo == TMO_W'(IRQ_TIMEOUT - 1)) begin
                    status_set = 1'b1; status_val = ST_ERR; state_n = S_REINIT_OFF;
                end
            S_WAIT_STAT: begin
                acc_req = 1'b1; acc_we = 1'b0; acc_adr = AW'(REG_CMDR);
                if (acc_done) begin
                    // Arbitration loss wins: the bus is gone, so STOP is skipped.
                    if (acc_rdata[STAT_AL]) begin
                        status_set = 1'b1; status_val = ST_AL; state_n = S_DONE;
                    end else if (acc_rdata[STAT_ERR]) begin
                        status_set = 1'b1; status_val = ST_ERR; state_n = S_REINIT_OFF;
                    end else if (acc_rdata[STAT_NAK] && (phase == PH_ADDR || phase == PH_WDATA)) begin
                        status_set = 1'b1; status_val = ST_NAK; state_n = S_STOP_CMD;
                    end else if (acc_rdata[STAT_DON]) begin
                        unique case (phase)
                            PH_BUS:   state_n = S_START_CMD;
                            PH_START: state_n = S_ADDR_DPR;
                            PH_ADDR:  state_n = rw ? S_RD_CMD : S_WR_WAIT;
                            PH_WDATA: begin
                                cnt_inc = 1'b1;
                                state_n = last_byte ? S_STOP_CMD : S_WR_WAIT;
                            end
                            PH_RDATA: state_n = S_RD_DPR;
                            PH_STOP:  state_n = S_DONE;
                            default:  state_n = S_DONE;
                        endcase
                    end else begin
                        status_set = 1'b1; status_val = ST_ERR; state_n = S_REINIT_OFF;
                    end
                end
            end
            S_REINIT_OFF: begin
                acc_req = 1'b1; acc_wdata = DW'(CSR_DISABLE);
                if (acc_done) state_n = S_REINIT_ON;
            end
            S_REINIT_ON: begin
                acc_req = 1'b1; acc_wdata = DW'(CSR_ENABLE);
                if (acc_done) state_n = S_DONE;
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_INIT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase    <= PH_BUS;
            status   <= ST_OK;
            rw       <= 1'b0;
            bus      <= '0;
            addr     <= '0;
            len      <= '0;
            cnt      <= '0;
            wbyte    <= '0;
            tmo      <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= (state == S_RD_DPR) && acc_done;
            if ((state == S_RD_DPR) && acc_done) rd_data <= acc_rdata[7:0];
            if (accept) begin
                rw     <= req_rw_i;
                bus    <= req_bus_i;
                addr   <= req_addr_i;
                len    <= req_len_i;
                cnt    <= '0;
                status <= bad_len ? ST_ERR : ST_OK;
            end else if (status_set) begin
                status <= status_val;
            end
            if (cnt_inc) cnt <= cnt + LEN_W'(1);
            if ((state == S_WR_WAIT) && wr_valid_i) wbyte <= wr_data_i;
            if ((state_n == S_WAIT_IRQ) && (state != S_WAIT_IRQ)) tmo <= '0;
            else if (state == S_WAIT_IRQ) tmo <= tmo + TMO_W'(1);
            unique case (state)
                S_BUS_CMD:   phase <= PH_BUS;
                S_START_CMD: phase <= PH_START;
                S_ADDR_CMD:  phase <= PH_ADDR;
                S_WR_CMD:    phase <= PH_WDATA;
                S_RD_CMD:    phase <= PH_RDATA;
                S_STOP_CMD:  phase <= PH_STOP;
                default:     phase <= phase;
            endcase
        end
    end

    assign req_ready_o = (state == S_IDLE);
    assign wr_ready_o  = (state == S_WR_WAIT);
    assign done_o      = (state == S_DONE);
    assign status_o    = status;
    assign rd_valid_o  = rd_valid;
    assign rd_data_o   = rd_data;

endmodule

// File: tb/tb_i2c_xfer_sequencer.sv
// Directed bench for i2c_xfer_sequencer against a small IICMB register model
// that logs every Wishbone access for comparison with hand-built sequences.
module tb_i2c_xfer_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0, req_rw = 1'b0;
    logic [7:0] req_bus = '0;
    logic [6:0] req_addr = '0;
    logic [5:0] req_len = '0;
    logic [7:0] wr_data = '0;
    logic       wr_valid = 1'b0;
    logic       req_ready, wr_ready, rd_valid, done, cyc, stb, we;
    logic [7:0] rd_data, dat_o, dat_r;
    logic [1:0] status, adr;
    logic       ack = 1'b0, irq = 1'b0;

    always #5 clk = ~clk;

    i2c_xfer_sequencer #(.IRQ_TIMEOUT(100)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_rw_i(req_rw),
        .req_bus_i(req_bus), .req_addr_i(req_addr), .req_len_i(req_len),
        .wr_data_i(wr_data), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
        .rd_data_o(rd_data), .rd_valid_o(rd_valid), .done_o(done), .status_o(status),
        .cyc_o(cyc), .stb_o(stb), .we_o(we), .adr_o(adr), .dat_o(dat_o),
        .dat_i(dat_r), .ack_i(ack), .irq_i(irq)
    );

    // IICMB register model
    logic        nak_addr = 1'b0, irq_block = 1'b0;
    logic [7:0]  rd_bytes [0:15];
    int          ridx = 0, log_n = 0, tick = 0, irq_cnt = 0;
    logic [10:0] log_v [0:511];
    int          log_t [0:511];
    logic        expect_addr = 1'b0, last_addr = 1'b0;

    always_comb begin
        dat_r = 8'h00;
        if (adr == 2'd2)      dat_r = (nak_addr && last_addr) ? 8'h40 : 8'h80;
        else if (adr == 2'd1) dat_r = rd_bytes[ridx[3:0]];
    end

    always @(posedge clk) begin
        tick <= tick + 1;
        if (rst) begin
            ack <= 1'b0; irq <= 1'b0; irq_cnt <= 0;
            expect_addr <= 1'b0; last_addr <= 1'b0;
        end else begin
            ack <= cyc && stb && !ack;
            if (irq_cnt != 0) begin
                irq_cnt <= irq_cnt - 1;
                if (irq_cnt == 1) irq <= 1'b1;
            end
            if (cyc && stb && ack) begin
                log_v[log_n] <= {we, adr, we ? dat_o : 8'h00};
                log_t[log_n] <= tick;
                log_n <= log_n + 1;
                if (we && adr == 2'd2) begin
                    if (!irq_block) irq_cnt <= 3;
                    last_addr   <= (dat_o == 8'h01) && expect_addr;
                    expect_addr <= (dat_o == 8'h04);
                end
                if (!we && adr == 2'd2) irq <= 1'b0;
                if (!we && adr == 2'd1) ridx <= ridx + 1;
            end
        end
    end

    int          n_vec = 0, n_err = 0;
    logic [10:0] exp_q[$];
    logic [7:0]  wr_q[$];
    logic [7:0]  rd_got[$];
    logic [1:0]  got_st;
    int          mark, stall_idx, stall_total, stall_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ew(input logic [1:0] a, input logic [7:0] d);
        exp_q.push_back({1'b1, a, d});
    endtask

    task automatic er(input logic [1:0] a);
        exp_q.push_back({1'b0, a, 8'h00});
    endtask

    task automatic ex_header(input logic [7:0] addr_byte);
        ew(2'd1, 8'h00); ew(2'd2, 8'h06); er(2'd2);
        ew(2'd2, 8'h04); er(2'd2);
        ew(2'd1, addr_byte); ew(2'd2, 8'h01); er(2'd2);
    endtask

    task automatic compare_log(input string p, input int from);
        check($sformatf("%s_count", p), 32'(log_n - from), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && from + i < log_n; i++)
            check($sformatf("%s_acc%0d", p, i), 32'(log_v[from + i]), 32'(exp_q[i]));
        exp_q.delete();
    endtask

    task automatic run_xfer(input string p, input logic rw, input logic [5:0] len);
        int wr_idx = 0, stall_left = stall_total;
        logic seen = 1'b0;
        rd_got.delete();
        stall_bad = 0;
        @(negedge clk);
        req_valid = 1'b1; req_rw = rw; req_bus = 8'h00; req_addr = 7'h22; req_len = len;
        @(negedge clk);
        req_valid = 1'b0;
        check({p, "_ready_drop"}, 32'(req_ready), 0);
        for (int c = 0; c < 3000; c++) begin
            if (done) begin seen = 1'b1; got_st = status; break; end
            if (rd_valid) rd_got.push_back(rd_data);
            if (wr_valid) begin wr_idx++; wr_valid = 1'b0; end
            if (wr_idx == stall_idx && stall_left > 0 && (wr_ready || stall_left < stall_total)) begin
                if (!wr_ready || cyc) stall_bad++;
                stall_left--;
            end else if (wr_ready && wr_idx < wr_q.size()) begin
                wr_valid = 1'b1; wr_data = wr_q[wr_idx];
            end
            @(negedge clk);
        end
        check({p, "_done_seen"}, 32'(seen), 1);
        @(negedge clk);
        check({p, "_done_pulse"}, 32'(done), 0);
        check({p, "_ready_back"}, 32'(req_ready), 1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rd_bytes[i] = 8'h00;
        rd_bytes[0] = 8'hA5; rd_bytes[1] = 8'h5A; rd_bytes[2] = 8'hFF;
        stall_idx = -1; stall_total = 0;

        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_cyc", 32'(cyc), 0);
        check("rst_done", 32'(done), 0);
        check("rst_status", 32'(status), 0);
        check("rst_wr_ready", 32'(wr_ready), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        mark = log_n;
        rst = 1'b0;
        for (int c = 0; c < 100 && !req_ready; c++) @(negedge clk);
        check("init_ready", 32'(req_ready), 1);

        // Write 00..03 to 0x22
        wr_q = '{8'h00, 8'h01, 8'h02, 8'h03};
        run_xfer("wr", 1'b0, 6'd4);
        ew(2'd0, 8'hC0); ex_header(8'h44);
        for (int b = 0; b < 4; b++) begin ew(2'd1, 8'(b)); ew(2'd2, 8'h01); er(2'd2); end
        ew(2'd2, 8'h05); er(2'd2);
        compare_log("wr", mark);
        check("wr_status", 32'(got_st), 0);

        // Read 3 bytes from 0x22
        mark = log_n; wr_q.delete();
        run_xfer("rd", 1'b1, 6'd3);
        ex_header(8'h45);
        ew(2'd2, 8'h02); er(2'd2); er(2'd1);
        ew(2'd2, 8'h02); er(2'd2); er(2'd1);
        ew(2'd2, 8'h03); er(2'd2); er(2'd1);
        ew(2'd2, 8'h05); er(2'd2);
        compare_log("rd", mark);
        check("rd_status", 32'(got_st), 0);
        check("rd_nbytes", 32'(rd_got.size()), 3);
        if (rd_got.size() == 3) begin
            check("rd_byte0", 32'(rd_got[0]), 32'h A5);
            check("rd_byte1", 32'(rd_got[1]), 32'h 5A);
            check("rd_byte2", 32'(rd_got[2]), 32'h FF);
        end

        // Address NAK
        mark = log_n; nak_addr = 1'b1; wr_q = '{8'h77, 8'h88};
        run_xfer("nak", 1'b0, 6'd2);
        nak_addr = 1'b0;
        ex_header(8'h44); ew(2'd2, 8'h05); er(2'd2);
        compare_log("nak", mark);
        check("nak_status", 32'(got_st), 1);

        // Write with a 50-cycle stall before the second byte
        mark = log_n; wr_q = '{8'h11, 8'h22, 8'h33};
        stall_idx = 1; stall_total = 50;
        run_xfer("bp", 1'b0, 6'd3);
        check("bp_stall_quiet", 32'(stall_bad), 0);
        stall_idx = -1; stall_total = 0;
        ex_header(8'h44);
        ew(2'd1, 8'h11); ew(2'd2, 8'h01); er(2'd2);
        ew(2'd1, 8'h22); ew(2'd2, 8'h01); er(2'd2);
        ew(2'd1, 8'h33); ew(2'd2, 8'h01); er(2'd2);
        ew(2'd2, 8'h05); er(2'd2);
        compare_log("bp", mark);
        check("bp_status", 32'(got_st), 0);

        // irq never arrives
        mark = log_n; irq_block = 1'b1; wr_q = '{8'h99};
        run_xfer("tmo", 1'b0, 6'd1);
        irq_block = 1'b0;
        check("tmo_status", 32'(got_st), 3);
        if (log_n - mark >= 3)
            check("tmo_wait_len", 32'((log_t[mark+2] - log_t[mark+1]) >= 100 &&
                                      (log_t[mark+2] - log_t[mark+1]) <= 110), 1);
        ew(2'd1, 8'h00); ew(2'd2, 8'h06); ew(2'd0, 8'h00); ew(2'd0, 8'hC0);
        compare_log("tmo", mark);

        // Reset while reading
        mark = log_n; wr_q.delete();
        @(negedge clk);
        req_valid = 1'b1; req_rw = 1'b1; req_addr = 7'h22; req_len = 6'd3;
        @(negedge clk);
        req_valid = 1'b0;
        begin
            logic hit = 1'b0;
            for (int c = 0; c < 500; c++) begin
                if (log_n > mark && log_v[log_n-1] == {1'b1, 2'd2, 8'h02}) begin hit = 1'b1; break; end
                @(negedge clk);
            end
            check("mrst_reached_rdata", 32'(hit), 1);
        end
        rst = 1'b1;
        @(negedge clk);
        check("mrst_cyc", 32'(cyc), 0);
        check("mrst_ready", 32'(req_ready), 0);
        repeat (2) begin
            @(negedge clk);
            check("mrst_no_pulse", 32'({done, rd_valid}), 0);
        end
        mark = log_n;
        rst = 1'b0;
        for (int c = 0; c < 100 && !req_ready; c++) begin
            check("mrst_no_pulse_rel", 32'({done, rd_valid}), 0);
            @(negedge clk);
        end
        check("mrst_ready_again", 32'(req_ready), 1);
        ew(2'd0, 8'hC0);
        compare_log("mrst_init", mark);

        // Bad lengths: zero and above MAX_LEN
        mark = log_n;
        run_xfer("len0", 1'b0, 6'd0);
        check("len0_status", 32'(got_st), 3);
        compare_log("len0", mark);
        mark = log_n;
        run_xfer("len33", 1'b1, 6'd33);
        check("len33_status", 32'(got_st), 3);
        compare_log("len33", mark);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
